stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
Command front-end that sits directly upstream of the 8-deep x 4-bit LIFO stack and drives it. It accepts push/pop commands over a valid/ready handshake and issues single-cycle registered Push/Pop pulses. It checks the stack's registered Full/Empty flags and rejects illegal commands. Popped data is captured into a one-entry output buffer with its own valid/ready handshake.

Parameters:
DW, 4, data width (matches stack Data_In/Data_Out)
DEPTH, 8, stack depth mirrored by the internal level counter
CNTW, 8, width of saturating reject counter

Ports:
Clk  input  1  clock, all state on rising edge
RstN  input  1  asynchronous active-low reset
Cmd_Valid  input  1  command present
Cmd_Op  input  1  0 = push, 1 = pop
Cmd_Data  input  DW  push payload
Cmd_Ready  output  1  controller can accept a command this cycle
Push  output  1  to stack, registered one-cycle pulse
Pop  output  1  to stack, registered one-cycle pulse
Data_In  output  DW  to stack, registered payload held with Push
Full  input  1  from stack, registered flag
Empty  input  1  from stack, registered flag
Stack_Data_Out  input  DW  from stack, valid the cycle after Pop is sampled
Rd_Valid  output  1  popped data available
Rd_Data  output  DW  popped data
Rd_Ready  input  1  consumer takes Rd_Data
Level  output  $clog2(DEPTH)+1  mirrored occupancy, 0..DEPTH
Rej_Count  output  CNTW  saturating count of rejected commands

Behaviour:
- Reset (RstN low, async): state IDLE, Push=0, Pop=0, Data_In=0, Rd_Valid=0, Rd_Data=0, Level=0, Rej_Count=0. Reset mid-operation abandons any in-flight command and drops Rd_Valid. The stack shares RstN, so both sides return empty together.
- States: IDLE, ISSUE_PUSH, ISSUE_POP, CAPTURE.
- Cmd_Ready = (state==IDLE) & (~Rd_Valid | Rd_Ready). This is combinational and never depends on Cmd_Valid.
- A command is accepted on an edge where Cmd_Valid & Cmd_Ready.
- Accepted push with Full=0: Push<=1, Data_In<=Cmd_Data, go to ISSUE_PUSH.
- Accepted pop with Empty=0: Pop<=1, go to ISSUE_POP.
- Accepted push with Full=1, or pop with Empty=1: no Push/Pop pulse, Rej_Count+1 (saturates at all-ones), stay in IDLE. The command is consumed, not retried.
- ISSUE_PUSH: Push<=0, Level+1, go to IDLE. Push is high for exactly one cycle. The stack updates Full on that same edge, so the next acceptance sees the correct flag. Push throughput is 1 per 2 cycles.
- ISSUE_POP: Pop<=0, Level-1, go to CAPTURE.
- CAPTURE: Rd_Data<=Stack_Data_Out, Rd_Valid<=1, go to IDLE. Pop latency is 3 edges from acceptance to Rd_Valid=1.
- Rd_Valid clears on an edge where Rd_Ready=1 and no capture is occurring. Rd_Data holds its value until the next capture.
- A capture can never coincide with Rd_Valid=1 without a same-edge consume, because acceptance is gated by Cmd_Ready. Rd_Ready and a new pop acceptance on the same edge are legal.
- Push and Pop are never high simultaneously.
- Level never exceeds DEPTH and never goes below 0. It always equals the stack occupancy.
- Cmd_Data is ignored for pops.
- Rd_Ready is ignored while Rd_Valid=0.

Test Plan:
1. Reset, then push 4'h3, 4'h7, 4'hA back-to-back with Cmd_Valid held -> Push pulses on alternate cycles with Data_In 3, 7, A; Level=3; Rej_Count=0.
2. With Rd_Ready=1, pop three times -> Rd_Data sequence A, 7, 3; each Rd_Valid appears 3 edges after acceptance; Level=0; Empty=1.
3. Push 9 values (0..8) -> the 9th is rejected with no Push pulse; Rej_Count=1; Level=8; then pop -> Rd_Data=7.
4. Pop on an empty stack -> no Pop pulse; Rej_Count increments; Rd_Valid stays 0.
5. Pop with Rd_Ready=0 -> Rd_Valid=1 and Cmd_Ready=0 while held. Next, present a pop with Rd_Ready=1 on the same edge -> accepted; the old data is consumed and new data is captured 3 edges later.
6. Assert RstN low during ISSUE_POP and while Rd_Valid=1 -> all outputs return to reset values immediately; after release a push of 4'h5 then a pop returns 5.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// Command, stack-side and read-side signals of the stack controller.
// slave = controller view; master = command source / stack / consumer view.
interface stack_ctrl_if #(
    parameter int DW    = 4,
    parameter int DEPTH = 8,
    parameter int CNTW  = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          Cmd_Valid;
    logic          Cmd_Op;
    logic [DW-1:0] Cmd_Data;
    logic          Cmd_Ready;
    logic          Push;
    logic          Pop;
    logic [DW-1:0] Data_In;
    logic          Full;
    logic          Empty;
    logic [DW-1:0] Stack_Data_Out;
    logic          Rd_Valid;
    logic [DW-1:0] Rd_Data;
    logic          Rd_Ready;
    logic [LW-1:0] Level;
    logic [CNTW-1:0] Rej_Count;

    modport slave (
        input  Cmd_Valid, Cmd_Op, Cmd_Data, Full, Empty, Stack_Data_Out, Rd_Ready,
        output Cmd_Ready, Push, Pop, Data_In, Rd_Valid, Rd_Data, Level, Rej_Count
    );

    modport master (
        output Cmd_Valid, Cmd_Op, Cmd_Data, Full, Empty, Stack_Data_Out, Rd_Ready,
        input  Cmd_Ready, Push, Pop, Data_In, Rd_Valid, Rd_Data, Level, Rej_Count
    );
endinterface

// File: rtl/stack_ctrl.sv
// Push/pop command front-end for an 8-deep LIFO: issues one-cycle Push/Pop
// pulses, rejects commands against Full/Empty, buffers popped data.
module stack_ctrl #(
    parameter int DW    = 4,
    parameter int DEPTH = 8,
    parameter int CNTW  = 8
) (
    input  logic           Clk,
    input  logic           RstN,
    stack_ctrl_if.slave    bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]   ONE_L = 1;
    localparam logic [CNTW-1:0] ONE_C = 1;

    typedef enum logic [1:0] {IDLE, ISSUE_PUSH, ISSUE_POP, CAPTURE} state_t;

    state_t          state_q, state_d;
    logic            push_q, push_d;
    logic            pop_q, pop_d;
    logic [DW-1:0]   din_q, din_d;
    logic            rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CNTW-1:0] rej_q, rej_d;
    logic            cmd_ready;
    logic            accept;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q    <= IDLE;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            din_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            level_q    <= '0;
            rej_q      <= '0;
        end else begin
            state_q    <= state_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            din_q      <= din_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            level_q    <= level_d;
            rej_q      <= rej_d;
        end
    end

    // The output buffer may be drained on the same edge a new pop is taken.
    assign cmd_ready = (state_q == IDLE) & (~rd_valid_q | bus.Rd_Ready);
    assign accept    = bus.Cmd_Valid & cmd_ready;

    always_comb begin
        state_d    = state_q;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        din_d      = din_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        level_d    = level_q;
        rej_d      = rej_q;

        if (rd_valid_q && bus.Rd_Ready)
            rd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.Cmd_Op && !bus.Full) begin
                        push_d  = 1'b1;
                        din_d   = bus.Cmd_Data;
                        state_d = ISSUE_PUSH;
                    end else if (bus.Cmd_Op && !bus.Empty) begin
                        pop_d   = 1'b1;
                        state_d = ISSUE_POP;
                    end else if (rej_q != {CNTW{1'b1}}) begin
                        rej_d = rej_q + ONE_C;
                    end
                end
            end
            ISSUE_PUSH: begin
                level_d = level_q + ONE_L;
                state_d = IDLE;
            end
            ISSUE_POP: begin
                level_d = level_q - ONE_L;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Stack output is valid one edge after it sampled Pop.
                rd_data_d  = bus.Stack_Data_Out;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Cmd_Ready = cmd_ready;
    assign bus.Push      = push_q;
    assign bus.Pop       = pop_q;
    assign bus.Data_In   = din_q;
    assign bus.Rd_Valid  = rd_valid_q;
    assign bus.Rd_Data   = rd_data_q;
    assign bus.Level     = level_q;
    assign bus.Rej_Count = rej_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: LIFO stack model, transaction-level reference model
// compared every cycle, plus directed checks with literal expectations.
module tb_stack_ctrl;
    logic Clk = 1'b0;
    logic RstN = 1'b0;
    always #5 Clk = ~Clk;

    stack_ctrl_if #(.DW(4), .DEPTH(8), .CNTW(8)) bus();

    stack_ctrl #(.DW(4), .DEPTH(8), .CNTW(8)) dut (
        .Clk  (Clk),
        .RstN (RstN),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stack model (the device being driven) ----------------
    logic [3:0] smem [8];
    int         scnt  = 0;
    logic [3:0] sdout = '0;
    always @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            scnt  <= 0;
            sdout <= '0;
        end else if (bus.Push && scnt < 8) begin
            smem[scnt] <= bus.Data_In;
            scnt       <= scnt + 1;
        end else if (bus.Pop && scnt > 0) begin
            sdout <= smem[scnt-1];
            scnt  <= scnt - 1;
        end
    end
    assign bus.Full           = (scnt == 8);
    assign bus.Empty          = (scnt == 0);
    assign bus.Stack_Data_Out = sdout;

    // ---------------- reference model: transaction schedule ----------------
    // Accepted push: pulse next cycle, busy 1 cycle, occupancy +1 one edge later.
    // Accepted pop: pulse next cycle, busy 2 cycles, data delivered 2 edges later.
    logic [3:0] mq [$];
    int         m_busy = 0, m_cap = 0, m_lvl = 0, m_dl = 0, m_rej = 0;
    logic       m_push = 0, m_pop = 0, m_rdv = 0, m_rdy_s = 0, m_capnow = 0;
    logic [3:0] m_din = 0, m_rdd = 0, m_capv = 0;

    always @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            m_busy = 0; m_cap = 0; m_lvl = 0; m_dl = 0; m_rej = 0;
            m_push = 0; m_pop = 0; m_rdv = 0; m_din = 0; m_rdd = 0; m_capv = 0;
            mq.delete();
        end else begin
            m_rdy_s = (m_busy == 0) && (!m_rdv || bus.Rd_Ready);
            m_push = 0;
            m_pop  = 0;
            m_lvl += m_dl;
            m_dl   = 0;
            m_capnow = 0;
            if (m_cap > 0) begin
                m_cap--;
                if (m_cap == 0) m_capnow = 1;
            end
            if (m_capnow) begin
                m_rdv = 1;
                m_rdd = m_capv;
            end else if (m_rdv && bus.Rd_Ready) begin
                m_rdv = 0;
            end
            if (m_busy > 0) m_busy--;
            if (bus.Cmd_Valid && m_rdy_s) begin
                if (!bus.Cmd_Op && mq.size() < 8) begin
                    mq.push_back(bus.Cmd_Data);
                    m_push = 1; m_din = bus.Cmd_Data; m_busy = 1; m_dl = 1;
                end else if (bus.Cmd_Op && mq.size() > 0) begin
                    m_capv = mq.pop_back();
                    m_pop = 1; m_busy = 2; m_cap = 2; m_dl = -1;
                end else begin
                    m_rej = (m_rej == 255) ? 255 : m_rej + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare + pulse monitor ----------------
    int n_push_seen = 0, n_pop_seen = 0;
    always @(negedge Clk) begin
        chk("Cmd_Ready", bus.Cmd_Ready, int'((m_busy == 0) && (!m_rdv || bus.Rd_Ready)));
        chk("Push", bus.Push, m_push);
        chk("Pop", bus.Pop, m_pop);
        chk("Data_In", bus.Data_In, m_din);
        chk("Rd_Valid", bus.Rd_Valid, m_rdv);
        chk("Rd_Data", bus.Rd_Data, m_rdd);
        chk("Level", bus.Level, m_lvl);
        chk("Rej_Count", bus.Rej_Count, m_rej);
        chk("Level_vs_stack", bus.Level, scnt);
        chk("Push_Pop_excl", bus.Push & bus.Pop, 0);
        if (bus.Push) n_push_seen++;
        if (bus.Pop)  n_pop_seen++;
    end

    // ---------------- stimulus helpers (all return at posedge+2) ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge Clk); #2; end
    endtask

    task automatic send(input logic op, input logic [3:0] d);
        logic rdy;
        bus.Cmd_Valid = 1'b1;
        bus.Cmd_Op    = op;
        bus.Cmd_Data  = d;
        for (int i = 0; i < 20; i++) begin
            #1 rdy = bus.Cmd_Ready;
            @(posedge Clk); #2;
            if (rdy) return;
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic pop_chk(input logic [3:0] exp);
        send(1'b1, 4'h0);
        bus.Cmd_Valid = 1'b0;
        step(1);
        chk("pop_lat_edge2", bus.Rd_Valid, 0);
        step(1);
        chk("pop_lat_edge3", bus.Rd_Valid, 1);
        chk("pop_data", bus.Rd_Data, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_Push"}, bus.Push, 0);
        chk({tag, "_Pop"}, bus.Pop, 0);
        chk({tag, "_Data_In"}, bus.Data_In, 0);
        chk({tag, "_Rd_Valid"}, bus.Rd_Valid, 0);
        chk({tag, "_Rd_Data"}, bus.Rd_Data, 0);
        chk({tag, "_Level"}, bus.Level, 0);
        chk({tag, "_Rej"}, bus.Rej_Count, 0);
        chk({tag, "_Cmd_Ready"}, bus.Cmd_Ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.Cmd_Valid = 1'b0;
        bus.Cmd_Op    = 1'b0;
        bus.Cmd_Data  = 4'h0;
        bus.Rd_Ready  = 1'b1;
        #7;
        chk_reset_vals("reset");
        @(posedge Clk); @(posedge Clk); #2;
        RstN = 1'b1;
        step(1);

        // 1: three back-to-back pushes
        base = n_push_seen;
        send(1'b0, 4'h3);
        send(1'b0, 4'h7);
        send(1'b0, 4'hA);
        bus.Cmd_Valid = 1'b0;
        step(2);
        chk("t1_level", bus.Level, 3);
        chk("t1_rej", bus.Rej_Count, 0);
        chk("t1_push_pulses", n_push_seen - base, 3);

        // 2: pop three with consumer ready
        pop_chk(4'hA);
        pop_chk(4'h7);
        pop_chk(4'h3);
        step(1);
        chk("t2_level", bus.Level, 0);
        chk("t2_empty", bus.Empty, 1);

        // 3: overfill by one, then drain
        base = n_push_seen;
        for (int i = 0; i < 9; i++) send(1'b0, 4'(i));
        bus.Cmd_Valid = 1'b0;
        step(2);
        chk("t3_rej", bus.Rej_Count, 1);
        chk("t3_level", bus.Level, 8);
        chk("t3_push_pulses", n_push_seen - base, 8);
        pop_chk(4'h7);
        for (int i = 6; i >= 0; i--) pop_chk(4'(i));
        step(1);
        chk("t3_drained", bus.Level, 0);

        // 4: pop on empty
        base = n_pop_seen;
        send(1'b1, 4'h0);
        bus.Cmd_Valid = 1'b0;
        step(3);
        chk("t4_pop_pulses", n_pop_seen - base, 0);
        chk("t4_rej", bus.Rej_Count, 2);
        chk("t4_rd_valid", bus.Rd_Valid, 0);

        // 5: back-pressure, then consume and pop on the same edge
        bus.Rd_Ready = 1'b0;
        send(1'b0, 4'hC);
        send(1'b0, 4'hD);
        pop_chk(4'hD);
        step(2);
        #1;
        chk("t5_ready_held", bus.Cmd_Ready, 0);
        chk("t5_rdv_held", bus.Rd_Valid, 1);
        chk("t5_data_held", bus.Rd_Data, 4'hD);
        bus.Rd_Ready = 1'b1;
        #1 chk("t5_ready_release", bus.Cmd_Ready, 1);
        pop_chk(4'hC);
        step(1);

        // 6: async reset while Rd_Valid=1, then during ISSUE_POP
        bus.Rd_Ready = 1'b0;
        send(1'b0, 4'h1);
        send(1'b0, 4'h2);
        pop_chk(4'h2);
        #1 RstN = 1'b0;
        #1 chk_reset_vals("t6_rst_a");
        @(posedge Clk); #2;
        RstN = 1'b1;
        bus.Rd_Ready = 1'b1;
        send(1'b0, 4'h9);
        send(1'b1, 4'h0);
        bus.Cmd_Valid = 1'b0;
        chk("t6_pop_inflight", bus.Pop, 1);
        #1 RstN = 1'b0;
        #1 chk_reset_vals("t6_rst_b");
        @(posedge Clk); #2;
        RstN = 1'b1;
        send(1'b0, 4'h5);
        pop_chk(4'h5);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
